// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the two-requester register-file write-back arbiter.
package rf_wb_arbiter_pkg;
  typedef enum logic {INIT, RUN} state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Requester and register-file write-port bundle; master = requesters/consumer side, slave = arbiter.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = rf_wb_arbiter_pkg::DATA_W_DEF,
  parameter int ADDR_W = rf_wb_arbiter_pkg::ADDR_W_DEF
);
  logic              V0, V1;
  logic              RDY0, RDY1;
  logic [ADDR_W-1:0] A0, A1;
  logic [DATA_W-1:0] D0, D1;
  logic              WE3;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic              BUSY;

  modport master (
    output V0, V1, A0, A1, D0, D1,
    input  RDY0, RDY1, WE3, A3, WD3, BUSY
  );

  modport slave (
    input  V0, V1, A0, A1, D0, D1,
    output RDY0, RDY1, WE3, A3, WD3, BUSY
  );
endinterface

// File: rtl/rf_wb_arbiter_rr_grant2.sv
// Two-way round-robin grant: a lone valid requester wins, a tie goes to the requester rr points at.
module rr_grant2 (
  input  logic [1:0] v,
  input  logic       rr,
  output logic [1:0] gnt
);
  assign gnt[0] = v[0] & (~v[1] | ~rr);
  assign gnt[1] = v[1] & (~v[0] |  rr);
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter with registered write port.
// Optional post-reset clear of registers 1..2**ADDR_W-1 is enabled by RF_INIT_CLEAR_EN.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic           CLK,
  input logic           RST,
  rf_wb_arbiter_if.slave bus
);
  logic [1:0]        w_v, w_gnt, w_rdy;
  logic              w_run, w_acc, w_sel;
  logic [ADDR_W-1:0] w_a;
  logic [DATA_W-1:0] w_d;

  logic              r_rr;
  logic              r_we;
  logic [ADDR_W-1:0] r_a3;
  logic [DATA_W-1:0] r_wd;

  assign w_v = {bus.V1, bus.V0};

  rr_grant2 u_grant (
    .v   (w_v),
    .rr  (r_rr),
    .gnt (w_gnt)
  );

`ifdef RF_INIT_CLEAR_EN
  state_e            r_state;
  logic [ADDR_W-1:0] r_cnt;

  assign w_run    = (r_state == RUN);
  assign bus.BUSY = (r_state == INIT);
`else
  assign w_run    = 1'b1;
  assign bus.BUSY = 1'b0;
`endif

  assign w_rdy    = w_run ? w_gnt : 2'b00;
  assign w_acc    = |w_rdy;
  assign w_sel    = w_rdy[REQ1];
  assign w_a      = w_sel ? bus.A1 : bus.A0;
  assign w_d      = w_sel ? bus.D1 : bus.D0;

  assign bus.RDY0 = w_rdy[REQ0];
  assign bus.RDY1 = w_rdy[REQ1];
  assign bus.WE3  = r_we;
  assign bus.A3   = r_a3;
  assign bus.WD3  = r_wd;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rr  <= 1'b0;
      r_we  <= 1'b0;
      r_a3  <= '0;
      r_wd  <= '0;
`ifdef RF_INIT_CLEAR_EN
      r_state <= INIT;
      r_cnt   <= ADDR_W'(1);
`endif
    end else begin
`ifdef RF_INIT_CLEAR_EN
      if (r_state == INIT) begin
        r_we  <= 1'b1;
        r_a3  <= r_cnt;
        r_wd  <= '0;
        r_cnt <= r_cnt + 1'b1;
        // the last clear write is issued on the same edge that hands over to RUN
        if (r_cnt == {ADDR_W{1'b1}})
          r_state <= RUN;
      end else
`endif
      begin
        // x0 writes are accepted but never reach the register file
        r_we <= w_acc && (w_a != '0);
        if (w_acc) begin
          r_a3 <= w_a;
          r_wd <= w_d;
          r_rr <= ~w_sel;
        end
      end
    end
  end
endmodule
